// File: rtl/bnnroll_sample_sequencer.sv
// bnnroll_sample_sequencer: streams feature vectors into a rolled BNN core and returns its predictions
//   clk, rst            clock, asynchronous active-high reset
//   s_valid/s_ready     input sample handshake, s_features carries the packed sample
//   core_features       held sample driven to the core's features input
//   core_rst            core reset, released only while the core evaluates
//   core_prediction     class reported by the core
//   m_valid/m_ready     result handshake, m_prediction = captured class, m_index = result ordinal
//   BNNROLL_PREFETCH_EN adds a one-entry input buffer so the next sample loads at the result handshake
module bnnroll_sample_sequencer #(
    parameter int FEAT_CNT = 11,
    parameter int FEAT_BITS = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT = 7,
    parameter int RUN_CYCLES = 2*HIDDEN_CNT+1,
    localparam int PRED_BITS = $clog2(CLASS_CNT),
    localparam int FW = FEAT_BITS*FEAT_CNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [FW-1:0]        s_features,
    output logic [FW-1:0]        core_features,
    output logic                 core_rst,
    input  logic [PRED_BITS-1:0] core_prediction,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PRED_BITS-1:0] m_prediction,
    output logic [15:0]          m_index
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [15:0] cnt;
    logic s_fire, m_fire, run_end, ld;
    logic [FW-1:0] ld_data;
    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;
    assign run_end = (state == RUN) && (cnt == 16'(RUN_CYCLES - 1));
    // the core is held in reset everywhere except while it evaluates
    assign core_rst = state != RUN;
`ifdef BNNROLL_PREFETCH_EN
    logic buf_full, ld_fresh;
    logic [FW-1:0] buf_data;
    assign s_ready = ~rst & ~buf_full;
    // a sample goes straight to the core when idle, or bypasses the empty buffer at the result handshake
    assign ld_fresh = s_fire & ((state == IDLE) | ((state == DONE) & m_fire));
    assign ld = ld_fresh | (m_fire & buf_full);
    assign ld_data = ld_fresh ? s_features : buf_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (s_fire & ~ld_fresh) begin
            buf_full <= 1'b1;
            buf_data <= s_features;
        end else if (m_fire & buf_full) begin
            buf_full <= 1'b0;
        end
    end
`else
    assign s_ready = ~rst & (state == IDLE);
    assign ld = s_fire;
    assign ld_data = s_features;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ld ? LOAD : IDLE;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = run_end ? DONE : RUN;
            DONE:    state_nx = m_fire ? (ld ? LOAD : IDLE) : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            core_features <= '0;
            m_valid <= 1'b0;
            m_prediction <= '0;
            m_index <= '0;
        end else begin
            state <= state_nx;
            cnt <= (state == RUN) ? cnt + 16'd1 : '0;
            if (ld) core_features <= ld_data;
            if (run_end) begin
                m_prediction <= core_prediction;
                m_valid <= 1'b1;
            end else if (m_fire) begin
                m_valid <= 1'b0;
                m_index <= m_index + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_bnnroll_sample_sequencer.sv
// tb_bnnroll_sample_sequencer: randomized self-checking bench with a behavioural core and result scoreboard
module tb_bnnroll_sample_sequencer;
    localparam int RC = 81;
    localparam int FW = 44;
`ifdef BNNROLL_PREFETCH_EN
    localparam int PERIOD = RC + 2;
`else
    localparam int PERIOD = RC + 3;
`endif
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic s_valid = 1'b0, m_ready = 1'b0, s_ready, core_rst, m_valid;
    logic [FW-1:0] s_features = '0, core_features;
    logic [2:0] core_prediction, m_prediction;
    logic [15:0] m_index;
    logic s_valid1 = 1'b0, m_ready1 = 1'b1, s_ready1, core_rst1, m_valid1;
    logic [FW-1:0] core_features1;
    logic [2:0] core_prediction1, m_prediction1;
    logic [15:0] m_index1;
    int errors = 0, checks = 0, exp_idx = 0, ccnt = 0;
    logic [2:0] exp_q[$];

    bnnroll_sample_sequencer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_features(s_features),
        .core_features(core_features), .core_rst(core_rst), .core_prediction(core_prediction),
        .m_valid(m_valid), .m_ready(m_ready), .m_prediction(m_prediction), .m_index(m_index)
    );
    bnnroll_sample_sequencer #(.RUN_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_features(s_features),
        .core_features(core_features1), .core_rst(core_rst1), .core_prediction(core_prediction1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_prediction(m_prediction1), .m_index(m_index1)
    );

    // behavioural core: class is a function of the features, valid only after RC-1 cycles out of reset
    function automatic logic [2:0] pred_of(input logic [FW-1:0] f);
        return (f == 44'h123456789AB) ? 3'd5 : 3'(f % 7);
    endfunction
    always @(posedge clk) ccnt <= core_rst ? 0 : ccnt + 1;
    assign core_prediction = (!core_rst && ccnt >= RC - 1) ? pred_of(core_features) : 3'd7;
    assign core_prediction1 = !core_rst1 ? pred_of(core_features1) : 3'd7;

    function automatic logic [FW-1:0] rnd();
        return FW'({$urandom, $urandom});
    endfunction

    task automatic send(input logic [FW-1:0] f, output int t);
        int n = 0;
        s_features = f;
        s_valid = 1'b1;
        while (!s_ready && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (!s_ready) begin errors++; $display("FAIL accept timeout: s_ready=%b want 1", s_ready); end
        t = cyc;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_mv(output int c);
        int n = 0;
        while (!m_valid && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (!m_valid) begin errors++; $display("FAIL m_valid timeout: m_valid=%b want 1", m_valid); end
        c = cyc;
    endtask

    task automatic take();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        exp_idx++;
    endtask

    task automatic test_reset(input string tag);
        logic [63:0] act[6];
        logic [63:0] req[6];
        string nm[6];
        nm = '{"s_ready", "core_rst", "core_features", "m_valid", "m_prediction", "m_index"};
        req = '{64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0};
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) #1; else @(negedge clk);
            act = '{64'(s_ready), 64'(core_rst), 64'(core_features), 64'(m_valid), 64'(m_prediction), 64'(m_index)};
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (act[k] !== req[k]) begin
                    errors++;
                    $display("FAIL reset %s %s: got %0h want %0h", tag, nm[k], act[k], req[k]);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        exp_idx = 0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset %s s_ready after release: got %b want 1", tag, s_ready); end
    endtask

    task automatic test_single();
        logic [FW-1:0] f = 44'h123456789AB;
        int t, c;
        s_features = f;
        s_valid = 1'b1;
        checks++;
        if (core_rst !== 1'b1) begin errors++; $display("FAIL single core_rst idle: got %b want 1", core_rst); end
        wait_accept: begin
            int n = 0;
            while (!s_ready && n < 50) begin @(negedge clk); n++; end
        end
        t = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        checks += 3;
        if (core_rst !== 1'b1) begin errors++; $display("FAIL single core_rst load: got %b want 1", core_rst); end
        if (core_features !== f) begin errors++; $display("FAIL single core_features: got %h want %h", core_features, f); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL single s_ready load: got %b want 0", s_ready); end
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b0) begin errors++; $display("FAIL single core_rst run: got %b want 0", core_rst); end
        wait_mv(c);
        checks += 3;
        if (c - t - 1 !== RC + 1) begin errors++; $display("FAIL single latency: got %0d want %0d", c - t - 1, RC + 1); end
        if (m_prediction !== 3'd5) begin errors++; $display("FAIL single prediction: got %0d want 5", m_prediction); end
        if (m_index !== 16'(exp_idx)) begin errors++; $display("FAIL single index: got %0d want %0d", m_index, exp_idx); end
        take();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] f = rnd();
        int t, c;
        send(f, t);
        wait_mv(c);
        for (int i = 0; i < 30; i++) begin
            checks += 3;
            if (m_valid !== 1'b1) begin errors++; $display("FAIL bp m_valid cyc %0d: got %b want 1", i, m_valid); end
            if (m_prediction !== pred_of(f)) begin errors++; $display("FAIL bp prediction cyc %0d: got %0d want %0d", i, m_prediction, pred_of(f)); end
            if (m_index !== 16'(exp_idx)) begin errors++; $display("FAIL bp index cyc %0d: got %0d want %0d", i, m_index, exp_idx); end
`ifndef BNNROLL_PREFETCH_EN
            checks++;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL bp s_ready cyc %0d: got %b want 0", i, s_ready); end
`endif
            @(negedge clk);
        end
        take();
        checks += 2;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL bp m_valid after: got %b want 0", m_valid); end
        if (m_index !== 16'(exp_idx)) begin errors++; $display("FAIL bp index after: got %0d want %0d", m_index, exp_idx); end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] f = rnd();
        int t, c;
        send(f, t);
        repeat (21) @(negedge clk);
        test_reset("mid-run");
        f = rnd();
        send(f, t);
        wait_mv(c);
        checks += 2;
        if (m_prediction !== pred_of(f)) begin errors++; $display("FAIL mid prediction: got %0d want %0d", m_prediction, pred_of(f)); end
        if (m_index !== 16'd0) begin errors++; $display("FAIL mid index: got %0d want 0", m_index); end
        take();
    endtask

    task automatic test_run1();
        for (int i = 0; i < 2; i++) begin
            logic [FW-1:0] f = rnd();
            int t, c, n = 0;
            s_features = f;
            s_valid1 = 1'b1;
            checks++;
            if (s_ready1 !== 1'b1) begin errors++; $display("FAIL run1 s_ready: got %b want 1", s_ready1); end
            t = cyc;
            @(negedge clk);
            s_valid1 = 1'b0;
            while (!m_valid1 && n < 20) begin @(negedge clk); n++; end
            c = cyc;
            checks += 4;
            if (m_valid1 !== 1'b1) begin errors++; $display("FAIL run1 m_valid timeout: got %b want 1", m_valid1); end
            if (c - t - 1 !== 2) begin errors++; $display("FAIL run1 latency: got %0d want 2", c - t - 1); end
            if (m_prediction1 !== pred_of(f)) begin errors++; $display("FAIL run1 prediction: got %0d want %0d", m_prediction1, pred_of(f)); end
            if (m_index1 !== 16'(i)) begin errors++; $display("FAIL run1 index: got %0d want %0d", m_index1, i); end
            @(negedge clk);
        end
    endtask

`ifdef BNNROLL_PREFETCH_EN
    task automatic test_prefetch();
        logic [FW-1:0] fa = rnd(), fb = rnd(), fc = rnd();
        int t, c, n = 0;
        bit leak = 0;
        send(fa, t);
        s_features = fb;
        s_valid = 1'b1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL pf s_ready for second: got %b want 1", s_ready); end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL pf s_ready buffer full: got %b want 0", s_ready); end
        s_features = fc;
        while (!m_valid && n < 300) begin if (s_ready) leak = 1; @(negedge clk); n++; end
        checks += 4;
        if (leak || s_ready) begin errors++; $display("FAIL pf third stall: got leak=%b want 0", leak | s_ready); end
        if (m_valid !== 1'b1) begin errors++; $display("FAIL pf m_valid timeout: got %b want 1", m_valid); end
        if (m_prediction !== pred_of(fa)) begin errors++; $display("FAIL pf result0: got %0d want %0d", m_prediction, pred_of(fa)); end
        if (m_index !== 16'(exp_idx)) begin errors++; $display("FAIL pf index0: got %0d want %0d", m_index, exp_idx); end
        take();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL pf s_ready after handshake: got %b want 1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            logic [2:0] p = (i == 0) ? pred_of(fb) : pred_of(fc);
            wait_mv(c);
            checks += 2;
            if (m_prediction !== p) begin errors++; $display("FAIL pf result%0d: got %0d want %0d", i + 1, m_prediction, p); end
            if (m_index !== 16'(exp_idx)) begin errors++; $display("FAIL pf index%0d: got %0d want %0d", i + 1, m_index, exp_idx); end
            @(negedge clk);
            exp_idx++;
        end
        m_ready = 1'b0;
        leak = 0;
        repeat (RC + 10) begin if (m_valid) leak = 1; @(negedge clk); end
        checks++;
        if (leak) begin errors++; $display("FAIL pf extra result: got 1 want 0"); end
    endtask
`endif

    task automatic test_back_to_back(input int num);
        fork
            begin
                for (int i = 0; i < num; i++) begin
                    logic [FW-1:0] f = rnd();
                    int n = 0;
                    exp_q.push_back(pred_of(f));
                    s_features = f;
                    s_valid = 1'b1;
                    while (!s_ready && n < 300) begin @(negedge clk); n++; end
                    if (!s_ready) begin
                        checks++; errors++;
                        $display("FAIL b2b accept timeout %0d: got %b want 1", i, s_ready);
                        break;
                    end
                    @(negedge clk);
                end
                s_valid = 1'b0;
            end
            begin
                int last = 0;
                m_ready = 1'b1;
                for (int i = 0; i < num; i++) begin
                    int n = 0, c;
                    while (!m_valid && n < 300) begin @(negedge clk); n++; end
                    checks++;
                    if (!m_valid || exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL b2b result timeout %0d: got %b want 1", i, m_valid);
                        break;
                    end
                    c = cyc;
                    checks += 2;
                    if (m_prediction !== exp_q[0]) begin errors++; $display("FAIL b2b prediction %0d: got %0d want %0d", i, m_prediction, exp_q[0]); end
                    if (m_index !== 16'(exp_idx)) begin errors++; $display("FAIL b2b index %0d: got %0d want %0d", i, m_index, exp_idx); end
                    if (i > 0) begin
                        checks++;
                        if (c - last !== PERIOD) begin errors++; $display("FAIL b2b period %0d: got %0d want %0d", i, c - last, PERIOD); end
                    end
                    last = c;
                    void'(exp_q.pop_front());
                    exp_idx++;
                    @(negedge clk);
                end
                m_ready = 1'b0;
            end
        join
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset("power-on");
        test_single();
        test_backpressure();
        test_reset_mid();
        test_run1();
`ifdef BNNROLL_PREFETCH_EN
        test_prefetch();
`endif
        test_back_to_back(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
